// File: rtl/demux_stream_1xn.sv
// ============================================================================
// demux_stream_1xn : 1-to-N valid/ready stream demux, packet-locked routing,
//                    one register slice per output, out-of-range packets dropped
// Revision : 1.0
// ============================================================================
`default_nettype none

module demux_stream_1xn #(
   parameter int DATA_W = 8,
   parameter int N_OUT  = 4,
   parameter int SEL_W  = 2,
   parameter int CNT_W  = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [DATA_W-1:0]       s_data,
   input  logic [SEL_W-1:0]        s_sel,
   input  logic                    s_last,
   input  logic                    s_valid,
   output logic                    s_ready,
   output logic [N_OUT*DATA_W-1:0] m_data,
   output logic [N_OUT-1:0]        m_last,
   output logic [N_OUT-1:0]        m_valid,
   input  logic [N_OUT-1:0]        m_ready,
   output logic [CNT_W-1:0]        drop_cnt,
   output logic                    busy
);

   localparam logic [SEL_W:0] C_N_OUT = (SEL_W+1)'(N_OUT);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ROUTE = 2'd1,
      DROP  = 2'd2
   } state_t;

   state_t                    state_q;
   logic [SEL_W-1:0]          route_q;
   logic [CNT_W-1:0]          drop_cnt_q;
   logic [N_OUT-1:0]          m_valid_q;
   logic [N_OUT-1:0]          m_last_q;
   logic [N_OUT*DATA_W-1:0]   m_data_q;

   logic [SEL_W-1:0]          tgt_sel;
   logic                      sel_ok;
   logic                      routing;
   logic [N_OUT-1:0]          tgt_oh;
   logic                      ready_d;
   logic                      xfer;

   // The select only matters on a first beat; afterwards the locked route wins.
   always_comb begin
      tgt_sel = (state_q == IDLE) ? s_sel : route_q;
      sel_ok  = ({1'b0, s_sel} < C_N_OUT);
      routing = (state_q == ROUTE) || ((state_q == IDLE) && sel_ok);
      tgt_oh  = '0;
      ready_d = 1'b1;
      for (int i = 0; i < N_OUT; i++) begin
         if (routing && (tgt_sel == SEL_W'(i))) begin
            tgt_oh[i] = 1'b1;
            ready_d   = !m_valid_q[i] || m_ready[i];
         end
      end
   end

   assign xfer = s_valid && ready_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         route_q    <= '0;
         drop_cnt_q <= '0;
         m_valid_q  <= '0;
         m_last_q   <= '0;
         m_data_q   <= '0;
      end else begin
         for (int i = 0; i < N_OUT; i++) begin
            if (xfer && tgt_oh[i]) begin
               m_data_q[i*DATA_W +: DATA_W] <= s_data;
               m_last_q[i]                  <= s_last;
               m_valid_q[i]                 <= 1'b1;
            end else if (m_ready[i]) begin
               m_valid_q[i] <= 1'b0;
            end
         end

         if (xfer) begin
            case (state_q)
               IDLE: begin
                  if (sel_ok) begin
                     route_q <= s_sel;
                     if (!s_last) state_q <= ROUTE;
                  end else begin
                     if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + CNT_W'(1);
                     if (!s_last) state_q <= DROP;
                  end
               end
               ROUTE, DROP: begin
                  if (s_last) state_q <= IDLE;
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign s_ready  = ready_d;
   assign m_data   = m_data_q;
   assign m_last   = m_last_q;
   assign m_valid  = m_valid_q;
   assign drop_cnt = drop_cnt_q;
   assign busy     = (state_q != IDLE);

endmodule

`default_nettype wire
